dmem_responder: RTL and testbench

Data-memory responder serving the MEM stage's dmem request port (word-aligned address, lane-shifted write data, write/read enables, 4-bit byte mask). Holds a byte-enabled word RAM, applies a programmable number of wait states via a stall to the pipeline, and returns registered read data one cycle after the access for consumption in WB. Sits in the hart beside the core, opposite the MEM-stage dmem outputs.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_bram.sv | 38 +++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, mask constants
// and wait-state counter width.
package dmem_pkg;

    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_BUSY = 1'b1
    } dmem_state_e;

    localparam logic [3:0] DMEM_MASK_NONE = 4'h0;
    localparam logic [3:0] DMEM_MASK_WORD = 4'hF;

    localparam int DMEM_CNT_W = 4;

endpackage

// File: rtl/dmem_bram.sv
// Byte-enabled word RAM with a synchronous, registered read port whose output
// holds until the next read.
module dmem_bram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       i_we,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // RAM contents are deliberately left unreset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (i_we[n]) begin
                mem_q[i_idx][8*n +: 8] <= i_wdata[8*n +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_idx];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: wait-state FSM, fault detection and rvalid
// around dmem_bram. Optional address range check via DMEM_RESP_RANGE_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic        i_dmem_wen,
    input  logic        i_dmem_ren,
    input  logic [3:0]  i_dmem_mask,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_rvalid,
    output logic        o_dmem_stall,
    output logic        o_dmem_fault
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] WAIT_M1 =
        (WAIT_CYCLES > 0) ? DMEM_CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_e           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                  rvalid_q, fault_q;
    logic                  req, access, stall;
    logic                  in_range, conflict, do_read;
    logic [3:0]            byte_we;
    logic [IDX_W-1:0]      idx;

    assign req      = i_dmem_wen | i_dmem_ren;
    assign conflict = i_dmem_wen & i_dmem_ren;
    assign idx      = IDX_W'((i_dmem_addr - BASE_ADDR) >> 2);

`ifdef DMEM_RESP_RANGE_CHECK_EN
    // Unsigned offset makes addresses below BASE_ADDR wrap high and fail too
    assign in_range = ((i_dmem_addr - BASE_ADDR) < 32'(4 * DEPTH_WORDS));
`else
    assign in_range = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DMEM_IDLE: begin
                if (req && (WAIT_CYCLES > 0)) begin
                    state_d = DMEM_BUSY;
                    cnt_d   = WAIT_M1;
                end
            end
            DMEM_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DMEM_CNT_W'(1);
                end else begin
                    state_d = DMEM_IDLE;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    // Gating on rst_n keeps stall low and blocks any RAM write while reset is held
    always_comb begin
        stall  = 1'b0;
        access = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                if (WAIT_CYCLES == 0) begin
                    access = req;
                end else begin
                    stall = req;
                end
            end
            DMEM_BUSY: begin
                stall  = (cnt_q != '0);
                access = (cnt_q == '0) & req;
            end
            default: ;
        endcase
        if (!rst_n) begin
            stall  = 1'b0;
            access = 1'b0;
        end
    end

    assign do_read = access & i_dmem_ren & ~i_dmem_wen & in_range;
    assign byte_we = {4{access & i_dmem_wen & ~i_dmem_ren & in_range}} & i_dmem_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            rvalid_q <= do_read;
            fault_q  <= access & (conflict | ~in_range);
        end
    end

    dmem_bram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bram (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (byte_we),
        .i_re   (do_read),
        .i_idx  (idx),
        .i_wdata(i_dmem_wdata),
        .o_rdata(o_dmem_rdata)
    );

    assign o_dmem_rvalid = rvalid_q;
    assign o_dmem_stall  = stall;
    assign o_dmem_fault  = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with no wait states, one with three,
// checked every cycle against a transaction-level timeline model.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          DEPTH = 1024;
    localparam int          NCYC  = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        wen    [2];
    logic        ren    [2];
    logic [3:0]  mask   [2];
    logic [31:0] rdata  [2];
    logic        rvalid [2];
    logic        stall  [2];
    logic        fault  [2];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .i_dmem_addr(addr[0]), .i_dmem_wdata(wdata[0]),
        .i_dmem_wen(wen[0]), .i_dmem_ren(ren[0]), .i_dmem_mask(mask[0]),
        .o_dmem_rdata(rdata[0]), .o_dmem_rvalid(rvalid[0]),
        .o_dmem_stall(stall[0]), .o_dmem_fault(fault[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(BASE)) u_w3 (
        .clk(clk), .rst_n(rst_n),
        .i_dmem_addr(addr[1]), .i_dmem_wdata(wdata[1]),
        .i_dmem_wen(wen[1]), .i_dmem_ren(ren[1]), .i_dmem_mask(mask[1]),
        .o_dmem_rdata(rdata[1]), .o_dmem_rvalid(rvalid[1]),
        .o_dmem_stall(stall[1]), .o_dmem_fault(fault[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Expected output timeline, indexed by cycle number
    bit          ex_stall [2][NCYC];
    bit          ex_rv    [2][NCYC];
    bit          ex_flt   [2][NCYC];
    bit          rd_set   [2][NCYC];
    logic [31:0] rd_val   [2][NCYC];
    logic [31:0] mem_m    [2][DEPTH];
    logic [31:0] rd_exp   [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%08h want=%08h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NCYC) begin
            for (int d = 0; d < 2; d++) begin
                if (rd_set[d][cyc]) rd_exp[d] = rd_val[d][cyc];
                chk($sformatf("stall%0d", d),  32'(stall[d]),  32'(ex_stall[d][cyc]));
                chk($sformatf("rvalid%0d", d), 32'(rvalid[d]), 32'(ex_rv[d][cyc]));
                chk($sformatf("fault%0d", d),  32'(fault[d]),  32'(ex_flt[d][cyc]));
                chk($sformatf("rdata%0d", d),  rdata[d],       rd_exp[d]);
            end
        end
    end

    // Called just after a rising edge; returns just after the access-result edge.
    task automatic txn(input int d, input bit we, input bit re, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m);
        int w, c, acc, idx;
        logic [31:0] off;
        bit inr;
        w   = (d == 0) ? 0 : 3;
        c   = cyc;
        acc = c + w + 1;
        off = a - BASE;
        idx = int'(off[11:2]);
`ifdef DMEM_RESP_RANGE_CHECK_EN
        inr = (off < 32'(4 * DEPTH));
`else
        inr = 1'b1;
`endif
        for (int k = 0; k < w; k++) ex_stall[d][c + k] = 1'b1;
        if ((we && re) || !inr) begin
            ex_flt[d][acc] = 1'b1;
        end else if (re) begin
            ex_rv[d][acc]  = 1'b1;
            rd_set[d][acc] = 1'b1;
            rd_val[d][acc] = mem_m[d][idx];
        end else if (we) begin
            for (int n = 0; n < 4; n++)
                if (m[n]) mem_m[d][idx][8*n +: 8] = wd[8*n +: 8];
        end
        addr[d] = a; wdata[d] = wd; wen[d] = we; ren[d] = re; mask[d] = m;
        repeat (w + 1) @(posedge clk);
        #1;
        wen[d] = 1'b0;
        ren[d] = 1'b0;
    endtask

    initial begin
        rd_exp[0] = '0;
        rd_exp[1] = '0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = BASE; wdata[d] = '0; wen[d] = 1'b0; ren[d] = 1'b0; mask[d] = 4'hF;
        end
        // Request during reset must not raise stall
        ren[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall[1]), 32'd0);
        chk("rst_rdata", rdata[1], 32'd0);
        ren[1] = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk); #1;

        // Zero wait states: full-word write then read
        txn(0, 1, 0, 32'h2000, 32'hDEADBEEF, 4'hF);
        txn(0, 0, 1, 32'h2000, 32'h0, 4'hF);
        chk("lit_rv0", 32'(rvalid[0]), 32'd1);
        chk("lit_rd0", rdata[0], 32'hDEADBEEF);

        // Byte-lane merge
        txn(0, 1, 0, 32'h2004, 32'h11223344, 4'hF);
        txn(0, 1, 0, 32'h2004, 32'h0000AB00, 4'b0010);
        txn(0, 0, 1, 32'h2004, 32'h0, 4'h0);
        chk("lit_byte", rdata[0], 32'h1122AB44);

        // Empty mask writes nothing
        txn(0, 1, 0, 32'h2004, 32'hFFFFFFFF, 4'h0);
        txn(0, 0, 1, 32'h2004, 32'h0, 4'hF);

        // Simultaneous wen/ren faults and leaves RAM and rdata alone
        txn(0, 1, 1, 32'h2000, 32'h0BADF00D, 4'hF);
        chk("lit_flt0", 32'(fault[0]), 32'd1);
        txn(0, 0, 1, 32'h2000, 32'h0, 4'hF);
        chk("lit_rd_after_flt", rdata[0], 32'hDEADBEEF);

        // Address range behaviour
`ifdef DMEM_RESP_RANGE_CHECK_EN
        txn(0, 1, 0, 32'h1FFC, 32'hFFFFFFFF, 4'hF);
        chk("lit_range_flt", 32'(fault[0]), 32'd1);
        txn(0, 0, 1, 32'h3000, 32'h0, 4'hF);
        chk("lit_range_rd_flt", 32'(fault[0]), 32'd1);
        txn(0, 0, 1, 32'h2000, 32'h0, 4'hF);
        chk("lit_range_word0", rdata[0], 32'hDEADBEEF);
`else
        txn(0, 0, 1, BASE + 32'(4 * DEPTH), 32'h0, 4'hF);
        chk("lit_wrap", rdata[0], 32'hDEADBEEF);
`endif

        // Three wait states: stall pattern and read latency
        txn(1, 1, 0, 32'h2008, 32'h55AA00FF, 4'hF);
        fork
            txn(1, 0, 1, 32'h2008, 32'h0, 4'hF);
            begin
                for (int k = 0; k < 4; k++) begin
                    #2;
                    chk($sformatf("lit_stall_%0d", k), 32'(stall[1]), (k < 3) ? 32'd1 : 32'd0);
                    @(posedge clk);
                end
                #3;
                chk("lit_rv3", 32'(rvalid[1]), 32'd1);
                chk("lit_rd3", rdata[1], 32'h55AA00FF);
            end
        join
        @(posedge clk); #1;

        // Back-to-back requests with wait states, including a fault
        txn(1, 1, 0, 32'h2000, 32'h13572468, 4'hF);
        txn(1, 0, 1, 32'h2000, 32'h0, 4'hF);
        txn(1, 1, 0, 32'h200C, 32'hA5A5A5A5, 4'b1001);
        txn(1, 1, 1, 32'h2008, 32'h0, 4'hF);
        txn(1, 0, 1, 32'h2008, 32'h0, 4'hF);

        // Reset in the second stall cycle of a write abandons it
        addr[1] = 32'h2000; wdata[1] = 32'hCAFEF00D; mask[1] = 4'hF; wen[1] = 1'b1;
        ex_stall[1][cyc] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd_set[d][cyc] = 1'b1;
            rd_val[d][cyc] = '0;
        end
        #1;
        chk("lit_rst_stall", 32'(stall[1]), 32'd0);
        @(posedge clk); #1;
        wen[1] = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk); #1;
        txn(1, 0, 1, 32'h2000, 32'h0, 4'hF);
        chk("lit_rst_old", rdata[1], 32'h13572468);
        txn(0, 0, 1, 32'h2004, 32'h0, 4'hF);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
